// File: rtl/oled_fb_arbiter.sv
// Framebuffer owner for the 8x128-byte OLED picture: one single-port RAM shared by the
// display refresh reads, a host read/write port and a fill/clear sequencer.
module oled_fb_arbiter #(
   parameter int N_PAGES   = 8,
   parameter int N_COLUMNS = 128,
   parameter int ADDR_W    = 10
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              disp_read_i,
   input  logic [2:0]        disp_page_i,
   input  logic [6:0]        disp_column_i,
   output logic [7:0]        disp_data_o,
   output logic              disp_ack_o,
   input  logic              host_req_i,
   input  logic              host_we_i,
   input  logic [ADDR_W-1:0] host_addr_i,
   input  logic [7:0]        host_wdata_i,
   output logic [7:0]        host_rdata_o,
   output logic              host_ack_o,
   input  logic              clear_start_i,
   input  logic [7:0]        clear_value_i,
   output logic              clear_busy_o,
   output logic              clear_done_o
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_DISP_RD = 3'd1;
   localparam logic [2:0] ST_HOST_RD = 3'd2;
   localparam logic [2:0] ST_HOST_WR = 3'd3;
   localparam logic [2:0] ST_CLEAR   = 3'd4;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PAGES * N_COLUMNS - 1);

   logic [2:0]        state_q, state_d;
   logic              disp_pend_q, disp_pend_d;
   logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
   logic              host_req_q;
   logic              host_done_q, host_done_d;
   logic              clr_busy_q, clr_busy_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic [7:0]        clr_value_q, clr_value_d;
   logic              clr_done_q, clr_done_d;
   logic [7:0]        disp_data_q, disp_data_d;
   logic              disp_ack_q, disp_ack_d;
   logic [7:0]        host_rdata_q, host_rdata_d;
   logic              host_ack_q, host_ack_d;

   logic              ram_we_s;
   logic [ADDR_W-1:0] ram_addr_s;
   logic [7:0]        ram_wdata_s;
   logic [7:0]        ram_rdata_q;
   logic [7:0]        mem_q [0:N_PAGES*N_COLUMNS-1];

   // Request latching, arbitration and RAM port steering
   always_comb begin
      state_d      = state_q;
      disp_pend_d  = disp_pend_q;
      disp_addr_d  = disp_addr_q;
      host_done_d  = host_req_q ? host_done_q : 1'b0;
      clr_busy_d   = clr_busy_q;
      clr_addr_d   = clr_addr_q;
      clr_value_d  = clr_value_q;
      clr_done_d   = 1'b0;
      disp_data_d  = disp_data_q;
      disp_ack_d   = 1'b0;
      host_rdata_d = host_rdata_q;
      host_ack_d   = 1'b0;
      ram_we_s     = 1'b0;
      ram_addr_s   = clr_addr_q;
      ram_wdata_s  = clr_value_q;

      if (disp_read_i && !disp_pend_q) begin
         disp_pend_d = 1'b1;
         disp_addr_d = {disp_page_i, disp_column_i};
      end else begin
         disp_pend_d = disp_pend_q;
      end

      if (clear_start_i && !clr_busy_q) begin
         clr_busy_d  = 1'b1;
         clr_addr_d  = {ADDR_W{1'b0}};
         clr_value_d = clear_value_i;
      end else begin
         clr_busy_d  = clr_busy_q;
      end

      case (state_q)
         ST_IDLE, ST_CLEAR: begin
            if (disp_pend_q) begin
               ram_addr_s  = disp_addr_q;
               disp_pend_d = 1'b0;
               state_d     = ST_DISP_RD;
            end else if (clr_busy_q) begin
               // One fill write per cycle; a pending display read suspends the fill in place
               ram_we_s = 1'b1;
               if (clr_addr_q == LAST_ADDR) begin
                  clr_busy_d = 1'b0;
                  clr_done_d = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  clr_addr_d = clr_addr_q + ADDR_W'(1'b1);
                  state_d    = ST_CLEAR;
               end
            end else if (host_req_q && !host_done_q && (state_q == ST_IDLE)) begin
               ram_addr_s  = host_addr_i;
               ram_wdata_s = host_wdata_i;
               if (host_we_i) begin
                  ram_we_s    = 1'b1;
                  host_ack_d  = 1'b1;
                  host_done_d = 1'b1;
                  state_d     = ST_HOST_WR;
               end else begin
                  state_d     = ST_HOST_RD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DISP_RD: begin
            disp_data_d = ram_rdata_q;
            disp_ack_d  = 1'b1;
            state_d     = clr_busy_q ? ST_CLEAR : ST_IDLE;
         end
         ST_HOST_RD: begin
            host_rdata_d = ram_rdata_q;
            host_ack_d   = 1'b1;
            host_done_d  = 1'b1;
            state_d      = ST_IDLE;
         end
         ST_HOST_WR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and output registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         disp_pend_q  <= 1'b0;
         disp_addr_q  <= {ADDR_W{1'b0}};
         host_req_q   <= 1'b0;
         host_done_q  <= 1'b0;
         clr_busy_q   <= 1'b0;
         clr_addr_q   <= {ADDR_W{1'b0}};
         clr_value_q  <= 8'h00;
         clr_done_q   <= 1'b0;
         disp_data_q  <= 8'h00;
         disp_ack_q   <= 1'b0;
         host_rdata_q <= 8'h00;
         host_ack_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         disp_pend_q  <= disp_pend_d;
         disp_addr_q  <= disp_addr_d;
         host_req_q   <= host_req_i;
         host_done_q  <= host_done_d;
         clr_busy_q   <= clr_busy_d;
         clr_addr_q   <= clr_addr_d;
         clr_value_q  <= clr_value_d;
         clr_done_q   <= clr_done_d;
         disp_data_q  <= disp_data_d;
         disp_ack_q   <= disp_ack_d;
         host_rdata_q <= host_rdata_d;
         host_ack_q   <= host_ack_d;
      end
   end

   // Framebuffer RAM: contents survive reset, but a write in the reset cycle is suppressed
   always_ff @(posedge clk_i) begin
      if (ram_we_s && !reset_i) begin
         mem_q[ram_addr_s] <= ram_wdata_s;
      end
      ram_rdata_q <= mem_q[ram_addr_s];
   end

   assign disp_data_o  = disp_data_q;
   assign disp_ack_o   = disp_ack_q;
   assign host_rdata_o = host_rdata_q;
   assign host_ack_o   = host_ack_q;
   assign clear_busy_o = clr_busy_q;
   assign clear_done_o = clr_done_q;

endmodule

// File: tb/tb_oled_fb_arbiter.sv
// Directed, table-driven bench for oled_fb_arbiter with hand-computed expectations.
module tb_oled_fb_arbiter;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b1;
   logic       disp_read_i = 1'b0;
   logic [2:0] disp_page_i = 3'd0;
   logic [6:0] disp_column_i = 7'd0;
   logic [7:0] disp_data_o;
   logic       disp_ack_o;
   logic       host_req_i = 1'b0;
   logic       host_we_i = 1'b0;
   logic [9:0] host_addr_i = 10'd0;
   logic [7:0] host_wdata_i = 8'h00;
   logic [7:0] host_rdata_o;
   logic       host_ack_o;
   logic       clear_start_i = 1'b0;
   logic [7:0] clear_value_i = 8'h00;
   logic       clear_busy_o;
   logic       clear_done_o;

   int n_checks = 0;
   int n_fail = 0;

   oled_fb_arbiter dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .disp_read_i(disp_read_i), .disp_page_i(disp_page_i), .disp_column_i(disp_column_i),
      .disp_data_o(disp_data_o), .disp_ack_o(disp_ack_o),
      .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
      .host_wdata_i(host_wdata_i), .host_rdata_o(host_rdata_o), .host_ack_o(host_ack_o),
      .clear_start_i(clear_start_i), .clear_value_i(clear_value_i),
      .clear_busy_o(clear_busy_o), .clear_done_o(clear_done_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int         kind;   // 0 host write, 1 host read, 2 display read
      logic [9:0] addr;
      logic [7:0] data;
      int         lat;
   } vec_t;

   vec_t vecs [15];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic host_access(input logic we, input logic [9:0] addr, input logic [7:0] wdata,
                              output logic [7:0] rdata, output int lat);
      lat = 0;
      rdata = 8'hxx;
      host_req_i = 1'b1;
      host_we_i = we;
      host_addr_i = addr;
      host_wdata_i = wdata;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (host_ack_o) begin
            lat = i;
            rdata = host_rdata_o;
            break;
         end
      end
      host_req_i = 1'b0;
      host_we_i = 1'b0;
      tick();
   endtask

   task automatic disp_access(input logic [9:0] addr, output logic [7:0] rdata, output int lat);
      lat = 0;
      rdata = 8'hxx;
      disp_read_i = 1'b1;
      disp_page_i = addr[9:7];
      disp_column_i = addr[6:0];
      for (int i = 1; i <= 40; i++) begin
         tick();
         disp_read_i = 1'b0;
         if (disp_ack_o) begin
            lat = i;
            rdata = disp_data_o;
            break;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd;
      int lat, d_at, h_at, cnt, dn, hk, bad, n_rd, n_ack, max_lat, issue, post;

      vecs[0]  = '{0, 10'd261,  8'hA5, 2};
      vecs[1]  = '{0, 10'd0,    8'h11, 2};
      vecs[2]  = '{0, 10'd1023, 8'h22, 2};
      vecs[3]  = '{0, 10'd341,  8'h3C, 2};
      vecs[4]  = '{0, 10'd682,  8'hC3, 2};
      vecs[5]  = '{0, 10'd299,  8'h5A, 2};
      vecs[6]  = '{0, 10'd300,  8'h6B, 2};
      vecs[7]  = '{2, 10'd261,  8'hA5, 3};
      vecs[8]  = '{2, 10'd1023, 8'h22, 3};
      vecs[9]  = '{1, 10'd0,    8'h11, 3};
      vecs[10] = '{1, 10'd341,  8'h3C, 3};
      vecs[11] = '{2, 10'd682,  8'hC3, 3};
      vecs[12] = '{1, 10'd300,  8'h6B, 3};
      vecs[13] = '{0, 10'd261,  8'h5E, 2};
      vecs[14] = '{2, 10'd261,  8'h5E, 3};

      // reset state
      repeat (3) tick();
      reset_i = 1'b0;
      tick();
      check("reset_disp_data", disp_data_o, 8'h00);
      check("reset_host_rdata", host_rdata_o, 8'h00);
      check("reset_acks", {disp_ack_o, host_ack_o}, 2'b00);
      check("reset_clear", {clear_busy_o, clear_done_o}, 2'b00);

      // table of single accesses on an idle arbiter
      foreach (vecs[i]) begin
         if (vecs[i].kind == 2) begin
            disp_access(vecs[i].addr, rd, lat);
            check($sformatf("vec%0d_disp_data", i), rd, vecs[i].data);
         end else if (vecs[i].kind == 1) begin
            host_access(1'b0, vecs[i].addr, 8'h00, rd, lat);
            check($sformatf("vec%0d_host_rdata", i), rd, vecs[i].data);
         end else begin
            host_access(1'b1, vecs[i].addr, vecs[i].data, rd, lat);
         end
         check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      end

      // display and host read requested in the same cycle: display wins
      d_at = 0; h_at = 0; rd = 8'h00;
      disp_read_i = 1'b1; disp_page_i = 3'd7; disp_column_i = 7'd127;
      host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 10'd261;
      for (int i = 1; i <= 10; i++) begin
         tick();
         disp_read_i = 1'b0;
         if (disp_ack_o) begin d_at = i; check("same_cycle_disp_data", disp_data_o, 8'h22); end
         if (host_ack_o) begin h_at = i; rd = host_rdata_o; host_req_i = 1'b0; end
      end
      check("same_cycle_disp_lat", d_at, 3);
      check("same_cycle_host_lat", h_at, 5);
      check("same_cycle_host_data", rd, 8'h5E);

      // fill with periodic display reads interrupting it
      clear_value_i = 8'h3C; clear_start_i = 1'b1;
      tick();
      clear_start_i = 1'b0;
      n_rd = 0; n_ack = 0; max_lat = 0; issue = 0; dn = 0; post = 0;
      for (int c = 0; c < 3000; c++) begin
         if (dn == 0 && (c % 9) == 4) begin
            disp_read_i = 1'b1;
            disp_page_i = 3'(c % 8);
            disp_column_i = 7'(c % 128);
         end else begin
            disp_read_i = 1'b0;
         end
         tick();
         if (disp_read_i) begin issue = c; n_rd++; end
         if (disp_ack_o) begin
            n_ack++;
            if (c - issue + 1 > max_lat) max_lat = c - issue + 1;
         end
         if (clear_done_o) dn++;
         if (dn > 0) begin post++; if (post > 8) break; end
      end
      disp_read_i = 1'b0;
      check("fill_irq_max_lat_le4", (max_lat <= 4 && max_lat > 0), 1);
      check("fill_irq_ack_count", n_ack, n_rd);
      check("fill_irq_done_once", dn, 1);
      check("fill_irq_busy_low", clear_busy_o, 1'b0);
      disp_access(10'd0, rd, lat);    check("fill_irq_addr0", rd, 8'h3C);
      disp_access(10'd512, rd, lat);  check("fill_irq_addr512", rd, 8'h3C);
      disp_access(10'd1023, rd, lat); check("fill_irq_addr1023", rd, 8'h3C);

      // plain fill with a host read held off until it completes
      cnt = 0; dn = 0; hk = 0; bad = 0; rd = 8'h00;
      clear_value_i = 8'hFF; clear_start_i = 1'b1;
      host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 10'd777;
      for (int i = 1; i <= 1100; i++) begin
         tick();
         clear_start_i = 1'b0;
         if (clear_busy_o) cnt++;
         if (clear_done_o) dn++;
         if (host_ack_o) begin
            if (clear_busy_o || dn == 0) bad++;
            hk++; rd = host_rdata_o; host_req_i = 1'b0;
         end
      end
      host_req_i = 1'b0;
      check("fill_busy_cycles", cnt, 1024);
      check("fill_done_once", dn, 1);
      check("fill_host_stalled", bad, 0);
      check("fill_host_one_ack", hk, 1);
      check("fill_host_data", rd, 8'hFF);
      bad = 0;
      for (int a = 0; a < 1024; a++) begin
         disp_access(10'(a), rd, lat);
         if (rd !== 8'hFF || lat != 3) bad++;
      end
      check("fill_all_ff", bad, 0);

      // boundaries and a second display read while one is pending
      host_access(1'b1, 10'd0, 8'h11, rd, lat);    check("bnd_wr0_lat", lat, 2);
      host_access(1'b1, 10'd1023, 8'h22, rd, lat); check("bnd_wr1023_lat", lat, 2);
      cnt = 0; rd = 8'h00;
      disp_read_i = 1'b1; disp_page_i = 3'd0; disp_column_i = 7'd0;
      tick();
      disp_page_i = 3'd7; disp_column_i = 7'd127;
      for (int i = 0; i < 10; i++) begin
         tick();
         disp_read_i = 1'b0;
         if (disp_ack_o) begin cnt++; rd = disp_data_o; end
      end
      check("bnd_dropped_read_acks", cnt, 1);
      check("bnd_dropped_read_data", rd, 8'h11);
      disp_access(10'd1023, rd, lat);
      check("bnd_p7c127_data", rd, 8'h22);
      check("bnd_p7c127_lat", lat, 3);

      // reset in the middle of a fill
      host_access(1'b1, 10'd299, 8'h5A, rd, lat);
      host_access(1'b1, 10'd300, 8'h6B, rd, lat);
      clear_value_i = 8'h77; clear_start_i = 1'b1;
      tick();
      clear_start_i = 1'b0;
      repeat (300) tick();
      check("rst_fill_busy_before", clear_busy_o, 1'b1);
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      check("rst_fill_busy_after", clear_busy_o, 1'b0);
      check("rst_fill_disp_data", disp_data_o, 8'h00);
      dn = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (clear_done_o) dn++;
      end
      check("rst_fill_no_done", dn, 0);
      disp_access(10'd299, rd, lat);  check("rst_fill_addr299", rd, 8'h77);
      disp_access(10'd300, rd, lat);  check("rst_fill_addr300", rd, 8'h6B);
      host_access(1'b0, 10'd0, 8'h00, rd, lat);    check("rst_fill_addr0", rd, 8'h77);
      host_access(1'b0, 10'd1023, 8'h00, rd, lat); check("rst_fill_addr1023", rd, 8'h22);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
